// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC sequencer issuing one-cycle-latency imem reads into a 2-entry FIFO,
// drained by valid/ready, with redirect flushing buffered and in-flight words.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_rd_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [15:0] out_imm
);
  typedef enum logic {BOOT, FETCH} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ret_pc_q, ret_pc_d;
  logic [31:0] h_instr_q, h_instr_d, h_pc_q, h_pc_d;
  logic [31:0] t_instr_q, t_instr_d, t_pc_q, t_pc_d;
  logic [1:0]  count_q, count_d, slot;
  logic        inflight_q, inflight_d, kill_q, kill_d;
  logic        pop, push;
  logic [2:0]  occ;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      ret_pc_q   <= '0;
      h_instr_q  <= '0;
      h_pc_q     <= '0;
      t_instr_q  <= '0;
      t_pc_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ret_pc_q   <= ret_pc_d;
      h_instr_q  <= h_instr_d;
      h_pc_q     <= h_pc_d;
      t_instr_q  <= t_instr_d;
      t_pc_q     <= t_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end
  always_comb state_d = FETCH;
  // Occupancy counts the word returning this cycle, so every issue is guaranteed a slot.
  always_comb begin
    out_valid  = count_q != 2'd0;
    pop        = out_valid & out_ready;
    occ        = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    imem_rd_en = (state_q == FETCH) && !redirect_valid && (occ < 3'd2);
    imem_addr  = pc_q;
    out_instr  = h_instr_q;
    out_pc     = h_pc_q;
    out_imm    = h_instr_q[15:0];
  end
  always_comb begin
    push       = inflight_q & ~kill_q;
    slot       = count_q - {1'b0, pop};
    pc_d       = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : imem_rd_en ? pc_q + PC_STEP : pc_q;
    ret_pc_d   = imem_rd_en ? pc_q : ret_pc_q;
    inflight_d = imem_rd_en;
    kill_d     = redirect_valid & inflight_q;
    h_instr_d  = (push && slot == 2'd0) ? imem_rdata : pop ? t_instr_q : h_instr_q;
    h_pc_d     = (push && slot == 2'd0) ? ret_pc_q : pop ? t_pc_q : h_pc_q;
    t_instr_d  = (push && slot == 2'd1) ? imem_rdata : t_instr_q;
    t_pc_d     = (push && slot == 2'd1) ? ret_pc_q : t_pc_q;
    count_d    = redirect_valid ? 2'd0 : count_q - {1'b0, pop} + {1'b0, push};
  end
endmodule
